// File: rtl/fft_out_reorder_if.sv
// rtl/fft_out_reorder_if.sv - frame-in / bin-out stream bundle for fft_out_reorder
interface fft_out_reorder_if #(
  parameter int DW     = 32,
  parameter int NPOINT = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NPOINT*DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [3:0]           out_idx;
  logic                 out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong buffer turning bit-reversed FFT frames into natural-order bins
module fft_out_reorder #(
  parameter int DW     = 32,
  parameter int NPOINT = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_out_reorder_if.slave s,
  output logic [CNT_W-1:0] frame_cnt
);

  function automatic logic [3:0] bitrev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  logic [DW-1:0] mem [2][NPOINT];
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wr_bk;
  logic          rd_bk;
  logic [3:0]    cnt;
  logic          accept;
  logic          beat;
  logic          last_beat;
  logic [DW-1:0] rd_word;

  assign accept    = s.in_valid & ~full[wr_bk];
  assign beat      = full[rd_bk] & s.out_ready;
  assign last_beat = beat & (cnt == 4'd15);

  // accept and last beat never target the same bank, so both updates can land together
  always_comb begin
    full_nxt = full;
    if (accept)    full_nxt[wr_bk] = 1'b1;
    if (last_beat) full_nxt[rd_bk] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full      <= 2'b00;
      wr_bk     <= 1'b0;
      rd_bk     <= 1'b0;
      cnt       <= 4'd0;
      frame_cnt <= '0;
    end else begin
      full <= full_nxt;
      if (accept) wr_bk <= ~wr_bk;
      if (beat) cnt <= cnt + 4'd1;
      if (last_beat) begin
        rd_bk     <= ~rd_bk;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // bank contents survive reset; only the full flags decide what is valid
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NPOINT; k++) begin
        mem[wr_bk][k] <= s.in_data[k*DW +: DW];
      end
    end
  end

  assign rd_word     = mem[rd_bk][bitrev4(cnt)];
  assign s.in_ready  = ~full[wr_bk];
  assign s.out_valid = full[rd_bk];
  assign s.out_data  = full[rd_bk] ? rd_word : '0;
  assign s.out_idx   = full[rd_bk] ? cnt : 4'd0;
  assign s.out_last  = full[rd_bk] & (cnt == 4'd15);

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - scoreboard bench for fft_out_reorder against a frame-level model
module tb_fft_out_reorder;
  localparam int DW     = 32;
  localparam int NPOINT = 16;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [3:0]    idx;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] frame_cnt;

  fft_out_reorder_if #(.DW(DW), .NPOINT(NPOINT)) bus ();

  fft_out_reorder #(.DW(DW), .NPOINT(NPOINT), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (bus),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  beat_t exp_q[$];
  int    nbuf = 0;
  int    drained_total = 0;
  int    fcnt = 0;
  bit    send_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // bin f comes from slot whose 4-bit index is f read backwards
  function automatic int slot_of_bin(input int f);
    int r = 0;
    for (int b = 0; b < 4; b++) r = r * 2 + ((f >> b) % 2);
    return r;
  endfunction

  task automatic push_frame(input logic [NPOINT*DW-1:0] d);
    beat_t e;
    for (int f = 0; f < NPOINT; f++) begin
      e.data = d[slot_of_bin(f)*DW +: DW];
      e.idx  = 4'(f);
      e.last = (f == NPOINT - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_valid;
      exp_valid = (exp_q.size() > 0);
      chk("in_ready", bus.in_ready, nbuf < 2);
      chk("out_valid", bus.out_valid, exp_valid);
      chk("frame_cnt", frame_cnt, fcnt % 256);
      if (exp_valid) begin
        chk("out_data", bus.out_data, exp_q[0].data);
        chk("out_idx", bus.out_idx, exp_q[0].idx);
        chk("out_last", bus.out_last, exp_q[0].last);
      end else begin
        chk("idle_data", bus.out_data, 0);
        chk("idle_idx", bus.out_idx, 0);
        chk("idle_last", bus.out_last, 0);
      end
      if (!rst_n) begin
        exp_q.delete();
        nbuf = 0;
        fcnt = 0;
        drained_total = 0;
      end else begin
        bit acc;
        acc = bus.in_valid && (nbuf < 2);
        if (exp_valid && bus.out_ready) begin
          beat_t e;
          e = exp_q.pop_front();
          if (e.last) begin
            nbuf--;
            fcnt++;
            drained_total++;
          end
        end
        if (acc) begin
          nbuf++;
          push_frame(bus.in_data);
        end
      end
    end
  end

  function automatic logic [NPOINT*DW-1:0] rand_frame();
    logic [NPOINT*DW-1:0] d;
    for (int k = 0; k < NPOINT; k++) d[k*DW +: DW] = $urandom;
    return d;
  endfunction

  task automatic send_frame(input logic [NPOINT*DW-1:0] d);
    bit acc;
    bit ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout actual=0 required=1");
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && nbuf == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", ok, 1);
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid && bus.out_idx == idx) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_idx", ok, 1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NPOINT*DW-1:0] d;
    int gaps;
    bit started;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    do_reset(3);
    mon_en = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    bus.out_ready = 1'b1;
    for (int k = 0; k < NPOINT; k++) d[k*DW +: DW] = {16'(k), 16'(-k)};
    send_frame(d);
    wait_drain();
    chk("order_frame_cnt", frame_cnt, 1);

    d = rand_frame();
    send_frame(d);
    wait_idx(4'd6);
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall_idx", bus.out_idx, 6);
      chk("stall_data", bus.out_data, d[6*DW +: DW]);
    end
    bus.out_ready = 1'b1;
    wait_drain();

    bus.out_ready = 1'b0;
    fork
      begin
        for (int j = 0; j < 3; j++) send_frame(rand_frame());
      end
    join_none
    repeat (20) @(posedge clk);
    #1;
    chk("pp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    wait fork;
    wait_drain();

    do_reset(2);
    bus.out_ready = 1'b1;
    fork
      begin
        for (int j = 0; j < 256; j++) send_frame(rand_frame());
      end
    join_none
    gaps = 0;
    started = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      if (drained_total == 256) break;
      if (bus.out_valid) started = 1'b1;
      else if (started) gaps++;
    end
    wait fork;
    chk("cont_frames", drained_total, 256);
    chk("cont_gaps", gaps, 0);
    chk("cont_wrap", frame_cnt, 0);

    do_reset(1);
    bus.out_ready = 1'b0;
    send_frame(rand_frame());
    send_frame(rand_frame());
    bus.out_ready = 1'b1;
    wait_idx(4'd9);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    send_frame(rand_frame());
    wait_drain();

    send_done = 1'b0;
    fork
      begin
        for (int j = 0; j < 20; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          send_frame(rand_frame());
        end
        send_done = 1'b1;
      end
    join_none
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (send_done && exp_q.size() == 0) break;
    end
    wait fork;
    bus.out_ready = 1'b1;
    wait_drain();

    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
